// File: rtl/dll_pkg.sv
// Shared types and default sizes for the DLL delay-code controller.
package dll_pkg;

  typedef enum logic {SAR, TRACK} dll_ctrl_state_t;

  localparam int unsigned DEF_QW       = 10;
  localparam int unsigned DEF_MW       = 2;
  localparam int unsigned DEF_NW       = 4;
  localparam int unsigned DEF_LOCK_CNT = 4;

endpackage

// File: rtl/dll_frame_cnt.sv
// Frame sequencer: M/N counters with zero-clamp, frame-end strobe from the live M/N limits.
module dll_frame_cnt
  import dll_pkg::*;
#(
  parameter int unsigned MW = DEF_MW,
  parameter int unsigned NW = DEF_NW
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic [MW-1:0] m_i,
  input  logic [NW-1:0] n_i,
  output logic [MW-1:0] m_cnt_o,
  output logic [NW-1:0] n_cnt_o,
  output logic          fe_c_o
);

  logic [MW-1:0] m_cnt_q, m_cnt_d, m_eff;
  logic [NW-1:0] n_cnt_q, n_cnt_d, n_eff;

  // A counter beyond a freshly lowered limit falls back to 1 without ever matching FE.
  always_comb begin
    m_eff   = (m_i == '0) ? MW'(1) : m_i;
    n_eff   = (n_i == '0) ? NW'(1) : n_i;
    fe_c_o  = (m_cnt_q == m_eff) && (n_cnt_q == n_eff);
    n_cnt_d = (n_cnt_q >= n_eff) ? NW'(1) : n_cnt_q + NW'(1);
    m_cnt_d = m_cnt_q;
    if (m_cnt_q > m_eff) begin
      m_cnt_d = MW'(1);
    end else if (n_cnt_q == n_eff) begin
      m_cnt_d = (m_cnt_q >= m_eff) ? MW'(1) : m_cnt_q + MW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      m_cnt_q <= MW'(1);
      n_cnt_q <= NW'(1);
    end else begin
      m_cnt_q <= m_cnt_d;
      n_cnt_q <= n_cnt_d;
    end
  end

  assign m_cnt_o = m_cnt_q;
  assign n_cnt_o = n_cnt_q;

endmodule

// File: rtl/dll_delay_ctrl.sv
// DLL delay-code controller: SAR coarse search, then +/-1 tracking with reversal-based lock.
// Optional DLL_CTRL_DITHER_FILTER_EN: tracking steps only on two agreeing consecutive decisions.
module dll_delay_ctrl
  import dll_pkg::*;
#(
  parameter int unsigned QW       = DEF_QW,
  parameter int unsigned MW       = DEF_MW,
  parameter int unsigned NW       = DEF_NW,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic          clk_ext,
  input  logic          Reset_DLL,
  input  logic          COMP,
  input  logic [MW-1:0] M,
  input  logic [NW-1:0] N,
  input  logic          relock,
  output logic [MW-1:0] M_counter,
  output logic [NW-1:0] N_counter,
  output logic [QW-1:0] Q,
  output logic [QW-1:0] Q_next,
  output logic          busy,
  output logic          lock
);

  localparam int unsigned BW = (QW > 1) ? $clog2(QW) : 1;
  localparam int unsigned RW = $clog2(LOCK_CNT + 1);
  localparam logic [QW-1:0] Q_MAX = '1;
  localparam logic [QW-1:0] Q_MID = QW'(1) << (QW - 1);

  dll_ctrl_state_t state_q;
  logic [QW-1:0]   q_q, q_next_q, q_upd_c, q_trk_c;
  logic [BW-1:0]   bit_q;
  logic [RW-1:0]   rev_q;
  logic            busy_q, lock_q, have_dir_q, last_dir_q;
  logic            clr_c, fe_c, step_c;

  assign clr_c = Reset_DLL | relock;

  dll_frame_cnt #(
    .MW(MW),
    .NW(NW)
  ) u_frame_cnt (
    .clk_i  (clk_ext),
    .clr_i  (clr_c),
    .m_i    (M),
    .n_i    (N),
    .m_cnt_o(M_counter),
    .n_cnt_o(N_counter),
    .fe_c_o (fe_c)
  );

`ifdef DLL_CTRL_DITHER_FILTER_EN
  logic prev_comp_q, have_prev_q;

  // Last TRACK decision; forgotten whenever the search restarts.
  always_ff @(posedge clk_ext) begin
    if (clr_c || state_q == SAR) begin
      have_prev_q <= 1'b0;
      prev_comp_q <= 1'b0;
    end else if (fe_c) begin
      have_prev_q <= 1'b1;
      prev_comp_q <= COMP;
    end
  end
`endif

  always_comb begin
    q_upd_c = COMP ? q_next_q : q_q;
    q_trk_c = q_q;
    if (COMP && q_q != Q_MAX) begin
      q_trk_c = q_q + QW'(1);
    end else if (!COMP && q_q != '0) begin
      q_trk_c = q_q - QW'(1);
    end
`ifdef DLL_CTRL_DITHER_FILTER_EN
    step_c = have_prev_q && (COMP == prev_comp_q);
`else
    step_c = 1'b1;
`endif
  end

  always_ff @(posedge clk_ext) begin
    if (clr_c) begin
      state_q    <= SAR;
      q_q        <= '0;
      q_next_q   <= Q_MID;
      bit_q      <= BW'(QW - 1);
      busy_q     <= 1'b1;
      lock_q     <= 1'b0;
      rev_q      <= '0;
      have_dir_q <= 1'b0;
      last_dir_q <= 1'b0;
    end else if (fe_c) begin
      case (state_q)
        SAR: begin
          q_q <= q_upd_c;
          if (bit_q != '0) begin
            bit_q    <= bit_q - BW'(1);
            q_next_q <= q_upd_c | (QW'(1) << (bit_q - BW'(1)));
          end else begin
            state_q    <= TRACK;
            busy_q     <= 1'b0;
            q_next_q   <= q_upd_c;
            have_dir_q <= 1'b0;
          end
        end
        TRACK: begin
          if (step_c) begin
            q_q        <= q_trk_c;
            q_next_q   <= q_trk_c;
            have_dir_q <= 1'b1;
            last_dir_q <= COMP;
            // The first step after the search has no predecessor to compare against.
            if (have_dir_q && COMP != last_dir_q) begin
              if (rev_q != RW'(LOCK_CNT)) rev_q <= rev_q + RW'(1);
              if (rev_q >= RW'(LOCK_CNT - 1)) lock_q <= 1'b1;
            end else if (have_dir_q) begin
              rev_q  <= '0;
              lock_q <= 1'b0;
            end
          end
        end
        default: state_q <= SAR;
      endcase
    end
  end

  assign Q      = q_q;
  assign Q_next = q_next_q;
  assign busy   = busy_q;
  assign lock   = lock_q;

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Randomized bench for dll_delay_ctrl against an integer reference model of the frame/SAR/track rules.
module tb_dll_delay_ctrl;

  localparam int QW = 10;
  localparam int MW = 2;
  localparam int NW = 4;
  localparam int LOCK_CNT = 4;
  localparam int QMAX = (1 << QW) - 1;
`ifdef DLL_CTRL_DITHER_FILTER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic          clk_ext = 1'b0;
  logic          Reset_DLL = 1'b1;
  logic          COMP = 1'b0;
  logic [MW-1:0] M = '0;
  logic [NW-1:0] N = '0;
  logic          relock = 1'b0;
  logic [MW-1:0] M_counter;
  logic [NW-1:0] N_counter;
  logic [QW-1:0] Q, Q_next;
  logic          busy, lock;

  int total = 0;
  int bad = 0;

  // reference model state
  int em = 1, en = 1, eq = 0, eqn = 1 << (QW - 1), ebit = QW - 1;
  bit etrack = 0, ebusy = 1, elock = 0;
  int erev = 0;
  bit have_dir = 0, last_dir = 0, have_prev = 0, prev_comp = 0;

  dll_delay_ctrl #(.QW(QW), .MW(MW), .NW(NW), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_ext  (clk_ext),
    .Reset_DLL(Reset_DLL),
    .COMP     (COMP),
    .M        (M),
    .N        (N),
    .relock   (relock),
    .M_counter(M_counter),
    .N_counter(N_counter),
    .Q        (Q),
    .Q_next   (Q_next),
    .busy     (busy),
    .lock     (lock)
  );

  always #5 clk_ext = ~clk_ext;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_cycle();
    int meff, neff, nm, nn;
    bit fe, cmp, step;
    meff = (int'(M) == 0) ? 1 : int'(M);
    neff = (int'(N) == 0) ? 1 : int'(N);
    cmp  = COMP;
    fe   = (em == meff) && (en == neff);
    if (Reset_DLL || relock) begin
      em = 1; en = 1; eq = 0; eqn = 1 << (QW - 1); ebit = QW - 1;
      etrack = 0; ebusy = 1; elock = 0; erev = 0;
      have_dir = 0; have_prev = 0; prev_comp = 0;
      return;
    end
    nn = (en >= neff) ? 1 : en + 1;
    if (em > meff) nm = 1;
    else if (en == neff) nm = (em >= meff) ? 1 : em + 1;
    else nm = em;
    em = nm; en = nn;
    if (!fe) return;
    if (!etrack) begin
      if (cmp) eq = eqn;
      if (ebit > 0) begin
        ebit--;
        eqn = eq | (1 << ebit);
      end else begin
        etrack = 1; ebusy = 0; eqn = eq;
        have_dir = 0; have_prev = 0;
      end
    end else begin
      step = DITHER ? (have_prev && cmp == prev_comp) : 1'b1;
      have_prev = 1; prev_comp = cmp;
      if (step) begin
        eq = cmp ? ((eq < QMAX) ? eq + 1 : QMAX) : ((eq > 0) ? eq - 1 : 0);
        eqn = eq;
        if (have_dir) begin
          if (cmp != last_dir) begin
            if (erev < LOCK_CNT) erev++;
            if (erev >= LOCK_CNT) elock = 1;
          end else begin
            erev = 0; elock = 0;
          end
        end
        have_dir = 1; last_dir = cmp;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit rl, input bit cmp);
    Reset_DLL = rst; relock = rl; COMP = cmp;
    model_cycle();
    @(posedge clk_ext);
    #1;
    check("M_counter", int'(M_counter), em);
    check("N_counter", int'(N_counter), en);
    check("Q", int'(Q), eq);
    check("Q_next", int'(Q_next), eqn);
    check("busy", int'(busy), int'(ebusy));
    check("lock", int'(lock), int'(elock));
  endtask

  initial begin
    int target;
    bit c;
    bit saw_lock;

    // reset state
    M = 2'd3; N = 4'd4;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("rst_Q", int'(Q), 0);
    check("rst_Q_next", int'(Q_next), 512);
    check("rst_busy", int'(busy), 1);
    check("rst_cnt", int'({M_counter, N_counter}), 17);

    // COMP stuck high: SAR climbs to full scale, tracking saturates without lock
    for (int i = 0; i < 120; i++) cyc(0, 0, 1);
    check("sat_Q", int'(Q), 1023);
    check("sat_busy", int'(busy), 0);
    saw_lock = 0;
    for (int i = 0; i < 36; i++) begin
      cyc(0, 0, 1);
      if (lock) saw_lock = 1;
    end
    check("sat_hold_Q", int'(Q), 1023);
    check("sat_no_lock", int'(saw_lock), 0);

    // single-cycle frames, detector threshold 300
    M = '0 + 2'd1; N = 4'd1;
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, eqn <= 300);
    check("sar300_Q", int'(Q), 300);
    check("sar300_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, eqn <= 300);
    if (!DITHER) check("dither_lock", int'(lock), 1);

    // relock on an FE in TRACK discards that decision
    cyc(0, 1, 1);
    check("relock_Q", int'(Q), 0);
    check("relock_Qn", int'(Q_next), 512);
    check("relock_busy", int'(busy), 1);
    check("relock_lock", int'(lock), 0);

    // floor saturation, then an alternating pattern for the dither filter
    cyc(1, 0, 0);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0);
    check("floor_Q", int'(Q), 0);
    check("floor_lock", int'(lock), 0);
    cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("dither_seq_Q", int'(Q), DITHER ? 1 : 2);

    // zero limits: every cycle is a frame end
    M = '0; N = '0;
    cyc(1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1'($urandom_range(0, 1)));
    check("zero_cnt", int'({M_counter, N_counter}), 17);

    // shrinking N below the running count
    M = 2'd1; N = 4'd8;
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    check("shrink_pre", int'(N_counter), 5);
    N = 4'd2;
    cyc(0, 0, 1);
    check("shrink_wrap", int'(N_counter), 1);
    check("shrink_Q", int'(Q), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    // randomized traffic with a noisy threshold detector
    target = $urandom_range(0, QMAX);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        M = MW'($urandom);
        N = NW'($urandom);
      end
      if ($urandom_range(0, 499) == 0) target = $urandom_range(0, QMAX);
      c = (eqn <= target);
      if ($urandom_range(0, 9) == 0) c = ~c;
      cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 399) == 0, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
